// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch (F)
// and data load/store (D); one transaction in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int DATA_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pick_s;
  logic              f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
  logic              f_rvalid_q, f_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  // Next-state and next-output logic; outputs are registered one edge ahead
  // so each pulse lines up with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    pick_s       = OWN_F;
    f_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    f_rvalid_d   = 1'b0;
    d_rvalid_d   = 1'b0;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          if (f_req && d_req) begin
            pick_s = (DATA_PRIO != 0) ? OWN_D : ~last_owner_q;
          end else begin
            pick_s = d_req;
          end
          owner_d     = pick_s;
          we_d        = pick_s & d_we;
          mem_addr_d  = pick_s ? d_addr : f_addr;
          mem_wdata_d = pick_s ? d_wdata : {DATA_W{1'b0}};
          mem_en_d    = 1'b1;
          mem_we_d    = pick_s & d_we;
          f_gnt_d     = ~pick_s;
          d_gnt_d     = pick_s;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d        = 4'(MEM_LAT);
        last_owner_d = owner_q;
        state_d      = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
          if (owner_q == OWN_D) begin
            d_rdata_d  = we_q ? {DATA_W{1'b0}} : mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            f_rdata_d  = mem_rdata;
            f_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_F;
      last_owner_q <= OWN_D;
      we_q         <= 1'b0;
      cnt_q        <= 4'd0;
      f_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
      f_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      f_rdata_q    <= {DATA_W{1'b0}};
      d_rdata_q    <= {DATA_W{1'b0}};
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      f_gnt_q      <= f_gnt_d;
      d_gnt_q      <= d_gnt_d;
      f_rvalid_q   <= f_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign f_gnt     = f_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign f_rvalid  = f_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
